// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Write-to-read bypass in regfile_mp is built only when REGFILE_BYPASS_EN is defined.
package regfile_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int ZERO_REG      = 0;

   // Upper bound on write ports the priority helper can arbitrate.
   localparam int MAX_WR_PORTS  = 16;
   localparam int SEL_W         = $clog2(MAX_WR_PORTS);

   typedef struct packed {
      logic             hit;
      logic [SEL_W-1:0] idx;
   } port_sel_t;

   // Highest-indexed set bit wins, so later write ports override earlier ones.
   function automatic port_sel_t pri_sel(input logic [MAX_WR_PORTS-1:0] hits);
      port_sel_t sel;
      sel = '0;
      for (int j = 0; j < MAX_WR_PORTS; j++) begin
         if (hits[j]) begin
            sel.hit = 1'b1;
            sel.idx = SEL_W'(j);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per non-zero register plus a registered
// population count. Issue marks set a bit, writebacks clear it, set wins on a tie.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int  NREGS = NREGS_DEFAULT,
   parameter int  NWR   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset,
   // iss_valid is a one-cycle strobe with no ready: every issue mark is accepted.
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   output logic [NREGS-1:0]  busy,
   output logic [AW:0]       busy_count
);

   logic [NREGS-1:1] busy_q;
   logic [NREGS-1:1] busy_d;
   logic [NREGS-1:1] set_vec;
   logic [NREGS-1:1] clr_vec;
   logic [AW:0]      count_d;
   logic [AW:0]      count_q;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      busy_d  = '0;
      count_d = '0;
      for (int r = 1; r < NREGS; r++) begin
         set_vec[r] = iss_valid && (iss_rd == AW'(r));
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
               clr_vec[r] = 1'b1;
            end
         end
         // A new producer supersedes the one retiring on the same edge.
         busy_d[r] = set_vec[r] | (busy_q[r] & ~clr_vec[r]);
         count_d   = count_d + (AW+1)'(busy_d[r]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy       = {busy_q, 1'b0};
   assign busy_count = count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational reads, NWR synchronous writes,
// register 0 hardwired to zero. REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  XLEN  = XLEN_DEFAULT,
   parameter int  NREGS = NREGS_DEFAULT,
   parameter int  NRD   = 2,
   parameter int  NWR   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic [AW:0]         busy_count
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   // Later ports are applied last, so the highest-indexed port wins a collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .busy       (busy),
      .busy_count (busy_count)
   );

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] stored;

      assign ra     = rd_addr[i*AW +: AW];
      assign stored = (ra == AW'(ZERO_REG)) ? '0 : regs[ra];

`ifdef REGFILE_BYPASS_EN
      logic [MAX_WR_PORTS-1:0] hits;
      port_sel_t               sel;
      logic [XLEN-1:0]         byp_data;

      always_comb begin
         hits = '0;
         for (int j = 0; j < NWR; j++) begin
            hits[j] = wr_en[j] && (wr_addr[j*AW +: AW] == ra) && (ra != AW'(ZERO_REG));
         end
         sel      = pri_sel(hits);
         byp_data = '0;
         for (int j = 0; j < NWR; j++) begin
            if (sel.hit && (int'(sel.idx) == j)) begin
               byp_data = wr_data[j*XLEN +: XLEN];
            end
         end
      end

      // A bypass hit means the pending value is already on the write bus.
      assign rd_data[i*XLEN +: XLEN] = sel.hit ? byp_data : stored;
      assign rd_busy[i]              = busy[ra] && !sel.hit;
`else
      assign rd_data[i*XLEN +: XLEN] = stored;
      assign rd_busy[i]              = busy[ra];
`endif
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed feature tasks plus a randomised
// model-based run, with expected values queued at drive time and popped at compare.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clock;
   logic                reset;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic [AW:0]         busy_count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [XLEN-1:0]  exp_q[$];
   logic [XLEN-1:0]  exp_v;
   logic [XLEN-1:0]  mdl_mem [NREGS];
   logic [NREGS-1:0] mdl_busy;

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .busy_count (busy_count)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
   endtask

   task automatic drive_write(input int port, input logic [AW-1:0] addr,
                              input logic [XLEN-1:0] data);
      wr_en[port]                   = 1'b1;
      wr_addr[port*AW +: AW]        = addr;
      wr_data[port*XLEN +: XLEN]    = data;
   endtask

   task automatic drive_read(input int port, input logic [AW-1:0] addr);
      rd_addr[port*AW +: AW] = addr;
   endtask

   task automatic drive_issue(input logic [AW-1:0] rd);
      iss_valid = 1'b1;
      iss_rd    = rd;
   endtask

   // Crosses one rising edge and returns at the following falling edge.
   task automatic next_cycle();
      @(negedge clock);
      idle_inputs();
   endtask

   function automatic logic [XLEN-1:0] rdata(input int port);
      return rd_data[port*XLEN +: XLEN];
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_read(0, 5'd5);
      drive_read(1, 5'd31);
      exp_q.push_back('0);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL reset_rd5: got %h expected %h", rdata(0), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(1) !== exp_v) begin
         tests_failed++; $display("FAIL reset_rd31: got %h expected %h", rdata(1), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if ({30'd0, rd_busy} !== exp_v || busy_count !== '0) begin
         tests_failed++; $display("FAIL reset_busy: rd_busy=%b busy_count=%0d expected 0", rd_busy, busy_count);
      end
   endtask

   task automatic test_write();
      drive_write(0, 5'd3, 32'hDEADBEEF);
      drive_write(1, 5'd0, 32'h00001234);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0);
      next_cycle();
      drive_read(0, 5'd3);
      drive_read(1, 5'd0);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL write_a3: got %h expected %h", rdata(0), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(1) !== exp_v) begin
         tests_failed++; $display("FAIL write_a0: got %h expected %h", rdata(1), exp_v);
      end
   endtask

   task automatic test_conflict();
      drive_write(0, 5'd7, 32'h11);
      drive_write(1, 5'd7, 32'h22);
      exp_q.push_back(32'h22);
      next_cycle();
      drive_write(0, 5'd8, 32'h55);
      drive_write(1, 5'd8, 32'h44);
      exp_q.push_back(32'h44);
      next_cycle();
      drive_read(0, 5'd8);
      drive_read(1, 5'd7);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(1) !== exp_v) begin
         tests_failed++; $display("FAIL conflict_a7: got %h expected %h", rdata(1), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL conflict_a8: got %h expected %h", rdata(0), exp_v);
      end
   endtask

   task automatic test_scoreboard();
      // issue 9
      drive_issue(5'd9);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);
      next_cycle();
      drive_read(0, 5'd9);
      drive_read(1, 5'd10);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if ({31'd0, rd_busy[0]} !== exp_v || rd_busy[1] !== 1'b0) begin
         tests_failed++; $display("FAIL issue_busy: rd_busy=%b expected %b", rd_busy, {1'b0, exp_v[0]});
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (32'(busy_count) !== exp_v) begin
         tests_failed++; $display("FAIL issue_count: got %0d expected %0d", busy_count, exp_v);
      end
      // issue to already-busy 9, and an issue to 0 the cycle after
      drive_issue(5'd9);
      next_cycle();
      drive_issue(5'd0);
      exp_q.push_back(32'd1);
      next_cycle();
      drive_read(1, 5'd0);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (32'(busy_count) !== exp_v || rd_busy !== 2'b01) begin
         tests_failed++; $display("FAIL reissue: busy_count=%0d rd_busy=%b expected %0d/01", busy_count, rd_busy, exp_v);
      end
      // writeback clears
      drive_write(0, 5'd9, 32'h90);
      exp_q.push_back(32'h90);
      exp_q.push_back(32'd0);
      next_cycle();
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL wb_data: got %h expected %h", rdata(0), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (32'(busy_count) !== exp_v || rd_busy[0] !== 1'b0) begin
         tests_failed++; $display("FAIL wb_clear: busy_count=%0d rd_busy=%b expected 0", busy_count, rd_busy);
      end
      // same-edge issue and writeback: set wins, data still written
      drive_issue(5'd9);
      drive_write(1, 5'd9, 32'h99);
      exp_q.push_back(32'h99);
      exp_q.push_back(32'd1);
      next_cycle();
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL setclr_data: got %h expected %h", rdata(0), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (32'(busy_count) !== exp_v || rd_busy[0] !== 1'b1) begin
         tests_failed++; $display("FAIL setclr_busy: busy_count=%0d rd_busy=%b expected %0d/1", busy_count, rd_busy[0], exp_v);
      end
      drive_write(0, 5'd9, 32'h9);
      next_cycle();
   endtask

   task automatic test_bypass();
      drive_write(0, 5'd4, 32'h4444);
      drive_issue(5'd4);
      next_cycle();
      drive_read(0, 5'd4);
      drive_write(0, 5'd4, 32'hBEEF);
      drive_write(1, 5'd4, 32'hCAFE);
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'hCAFE);
      exp_q.push_back(32'd0);
`else
      exp_q.push_back(32'h4444);
      exp_q.push_back(32'd1);
`endif
      exp_q.push_back(32'hCAFE);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v) begin
         tests_failed++; $display("FAIL same_cycle_data: got %h expected %h", rdata(0), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if ({31'd0, rd_busy[0]} !== exp_v) begin
         tests_failed++; $display("FAIL same_cycle_busy: got %b expected %0d", rd_busy[0], exp_v);
      end
      next_cycle();
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v || rd_busy[0] !== 1'b0 || busy_count !== '0) begin
         tests_failed++; $display("FAIL next_cycle_data: got %h busy=%b count=%0d expected %h/0/0", rdata(0), rd_busy[0], busy_count, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      drive_issue(5'd12);
      next_cycle();
      reset = 1'b1;
      drive_write(0, 5'd12, 32'h5555);
      drive_issue(5'd13);
      next_cycle();
      reset = 1'b0;
      drive_read(0, 5'd12);
      drive_read(1, 5'd3);
      exp_q.push_back('0);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(0) !== exp_v || rd_busy[0] !== 1'b0) begin
         tests_failed++; $display("FAIL rst_mid_a12: data=%h busy=%b expected %h/0", rdata(0), rd_busy[0], exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (rdata(1) !== exp_v) begin
         tests_failed++; $display("FAIL rst_mid_a3: got %h expected %h", rdata(1), exp_v);
      end
      exp_v = exp_q.pop_front(); tests_run++;
      if (32'(busy_count) !== exp_v) begin
         tests_failed++; $display("FAIL rst_mid_count: got %0d expected %0d", busy_count, exp_v);
      end
   endtask

   task automatic test_random();
      logic [NWR-1:0]  en;
      logic [AW-1:0]   wa [NWR];
      logic [XLEN-1:0] wd [NWR];
      logic [AW-1:0]   ra [NRD];
      logic            iv;
      logic [AW-1:0]   ir;
      logic            eb;
      for (int r = 0; r < NREGS; r++) mdl_mem[r] = '0;
      mdl_busy = '0;
      for (int n = 0; n < 60; n++) begin
         for (int j = 0; j < NWR; j++) begin
            en[j] = 1'($urandom_range(0, 1));
            wa[j] = AW'($urandom_range(0, 7));
            wd[j] = $urandom();
            if (en[j]) drive_write(j, wa[j], wd[j]);
         end
         iv = 1'($urandom_range(0, 1));
         ir = AW'($urandom_range(0, 7));
         if (iv) drive_issue(ir);
         for (int i = 0; i < NRD; i++) begin
            ra[i] = AW'($urandom_range(0, 7));
            drive_read(i, ra[i]);
            exp_v = (ra[i] == '0) ? '0 : mdl_mem[ra[i]];
            eb    = (ra[i] != '0) && mdl_busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
               if (en[j] && wa[j] == ra[i] && ra[i] != '0) begin
                  exp_v = wd[j];
                  eb    = 1'b0;
               end
            end
`endif
            exp_q.push_back(exp_v);
            exp_q.push_back(XLEN'(eb));
         end
         exp_q.push_back(XLEN'($countones(mdl_busy)));
         #1;
         for (int i = 0; i < NRD; i++) begin
            exp_v = exp_q.pop_front(); tests_run++;
            if (rdata(i) !== exp_v) begin
               tests_failed++; $display("FAIL rand_data n=%0d p=%0d a=%0d: got %h expected %h", n, i, ra[i], rdata(i), exp_v);
            end
            exp_v = exp_q.pop_front(); tests_run++;
            if (XLEN'(rd_busy[i]) !== exp_v) begin
               tests_failed++; $display("FAIL rand_busy n=%0d p=%0d a=%0d: got %b expected %0d", n, i, ra[i], rd_busy[i], exp_v);
            end
         end
         exp_v = exp_q.pop_front(); tests_run++;
         if (XLEN'(busy_count) !== exp_v) begin
            tests_failed++; $display("FAIL rand_count n=%0d: got %0d expected %0d", n, busy_count, exp_v);
         end
         for (int j = 0; j < NWR; j++) begin
            if (en[j] && wa[j] != '0) mdl_mem[wa[j]] = wd[j];
            if (en[j]) mdl_busy[wa[j]] = 1'b0;
         end
         if (iv && ir != '0) mdl_busy[ir] = 1'b1;
         mdl_busy[0] = 1'b0;
         next_cycle();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset   = 1'b1;
      rd_addr = '0;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      test_reset();
      test_write();
      test_conflict();
      test_scoreboard();
      test_bypass();
      test_reset_mid();
      test_random();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++; $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next RISC-V core generation.
- Provides NRD asynchronous read ports and NWR synchronous write ports.
- Includes a per-register scoreboard (pending-write bits) with set-on-issue and clear-on-writeback.
- Sits between decode/issue (reads, issue marks) and writeback (writes, scoreboard clears); register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  per-port flag: register has a pending write and is not satisfied by bypass this cycle.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_valid  in  1  issue marks instruction destination as pending.
- iss_rd  in  AW  destination register of the issued instruction.
- busy_count  out  AW+1  number of registers currently marked pending.

Behaviour:
- Reset: all registers load 0; all scoreboard bits clear; busy_count = 0. Combinational outputs reflect the cleared state in the cycle after reset; the reset cycle ignores wr_en and iss_valid.
- Reads are combinational (0-cycle latency):
  - rd_data[i] = 0 when rd_addr[i] == 0.
  - Otherwise rd_data[i] is the stored value, subject to bypass (see Optional Feature).
- Writes: on the rising edge, for each port j with wr_en[j] and wr_addr[j] != 0, the register takes wr_data[j]. Writes to address 0 are discarded.
- Write-write conflict (same address on two enabled ports): the highest-indexed port wins, both for data and for the scoreboard clear.
- Scoreboard:
  - busy[r] is set on the edge when iss_valid && iss_rd == r && r != 0.
  - busy[r] is cleared on the edge when any enabled write port targets r.
  - Same edge, same register, set and clear together: set wins, since the new producer supersedes the retiring one. The data write still occurs.
  - busy[0] is permanently 0.
  - Issue to an already-busy register leaves it busy; there is no count per register.
- rd_busy[i] = busy[rd_addr[i]] && !(bypass hit on port i). It is always 0 for address 0.
- busy_count: registered population count of the busy bits, updated the same edge as the bits. Range 0..NREGS-1.
- No internal FSM beyond the scoreboard. All state is the register array plus NREGS-1 busy bits and the count register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if any enabled write port j has wr_addr[j] == rd_addr[i] != 0 in the current cycle, then:
  - rd_data[i] = wr_data[j], using the highest-indexed matching port.
  - rd_busy[i] = 0.
- Undefined: reads return pre-edge contents. A same-cycle write becomes visible from the next cycle, and rd_busy[i] reflects busy[] only.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREGS constants;
  - a zero-register address constant;
  - a priority-select helper function (highest matching write port).
- One natural sub-module: regfile_scoreboard, containing the busy bits, set/clear arbitration and busy_count. Data array and read/bypass muxing stay in the top.

Test Plan:
- Reset, then read ports 0,1 at addr 5 and 31 -> rd_data = 0 and 0, rd_busy = 0, busy_count = 0.
- Write port 0 with addr 3 = 0xDEADBEEF; next cycle read addr 3 -> 0xDEADBEEF. Write 0x1234 to addr 0 -> addr 0 still reads 0.
- Both write ports target addr 7: port0 = 0x11, port1 = 0x22 -> addr 7 reads 0x22.
- Issue rd = 9 -> busy_count = 1 and rd_busy = 1 for addr 9. Writeback to 9 -> busy cleared, count 0. Same-edge issue 9 plus writeback 9 -> busy stays 1, data updated.
- REGFILE_BYPASS_EN defined, write addr 4 = 0xCAFE while reading addr 4 in the same cycle -> rd_data = 0xCAFE, rd_busy = 0. Macro undefined -> old value returned, new value on the next cycle.
- Issue rd = 12, then assert reset the next cycle while a writeback to 12 is pending -> all registers 0, busy_count 0, writeback ignored.
